// File: rtl/tdm_demultiplexer_1_4.sv
// Rebuilds a 4-lane parallel frame from a sync-marked TDM sample stream; y/frame_valid update 1 edge after lane 3.
// No backpressure: valid_in=0 cycles simply stall the frame assembly, and frame rate is bounded only by input rate.
module tdm_demultiplexer_1_4 #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic               sync,
    input  logic [WIDTH-1:0]   d,
    output logic [4*WIDTH-1:0] y,
    output logic               frame_valid,
    output logic [1:0]         slot,
    output logic               locked,
    output logic               sync_err
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e             state_q;
    logic [1:0]         slot_q;
    logic [WIDTH-1:0]   shadow0_q;
    logic [WIDTH-1:0]   shadow1_q;
    logic [WIDTH-1:0]   shadow2_q;
    logic [4*WIDTH-1:0] y_q;
    logic               frame_valid_q;
    logic               sync_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= HUNT;
            slot_q        <= 2'd0;
            shadow0_q     <= '0;
            shadow1_q     <= '0;
            shadow2_q     <= '0;
            y_q           <= '0;
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
            if (valid_in) begin
                case (state_q)
                    HUNT: begin
                        if (sync) begin
                            shadow0_q <= d;
                            slot_q    <= 2'd1;
                            state_q   <= LOCKED;
                        end
                    end
                    LOCKED: begin
                        if (sync) begin
                            // An early sync abandons the partial frame but keeps alignment.
                            sync_err_q <= (slot_q != 2'd0);
                            shadow0_q  <= d;
                            slot_q     <= 2'd1;
                        end else if (slot_q == 2'd0) begin
                            sync_err_q <= 1'b1;
                            state_q    <= HUNT;
                        end else if (slot_q == 2'd3) begin
                            y_q           <= {d, shadow2_q, shadow1_q, shadow0_q};
                            frame_valid_q <= 1'b1;
                            slot_q        <= 2'd0;
                        end else begin
                            if (slot_q == 2'd1) begin
                                shadow1_q <= d;
                            end else begin
                                shadow2_q <= d;
                            end
                            slot_q <= slot_q + 2'd1;
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign y           = y_q;
    assign frame_valid = frame_valid_q;
    assign slot        = slot_q;
    assign locked      = (state_q == LOCKED);
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demultiplexer_1_4.sv
// Bench for tdm_demultiplexer_1_4 at WIDTH=4: directed vector table, hand-written stall/reset sequences, then random traffic vs a queue model.
module tb_tdm_demultiplexer_1_4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         valid_in;
    logic         sync;
    logic [W-1:0] d;
    logic [4*W-1:0] y;
    logic         frame_valid;
    logic [1:0]   slot;
    logic         locked;
    logic         sync_err;

    always #5 clk = ~clk;

    tdm_demultiplexer_1_4 #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .valid_in    (valid_in),
        .sync        (sync),
        .d           (d),
        .y           (y),
        .frame_valid (frame_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a frame is just the list of samples collected since the last sync.
    bit             m_locked;
    logic [W-1:0]   m_buf[$];
    logic [4*W-1:0] m_y;
    bit             m_fv;
    bit             m_err;

    typedef struct {
        bit             v;
        bit             s;
        logic [W-1:0]   d;
        logic [4*W-1:0] ey;
        bit             efv;
        logic [1:0]     eslot;
        bit             elk;
        bit             eerr;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4*W-1:0] ey, input bit efv,
                           input logic [1:0] eslot, input bit elk, input bit eerr);
        chk({tag, ".y"},           32'(y),           32'(ey));
        chk({tag, ".frame_valid"}, 32'(frame_valid), 32'(efv));
        chk({tag, ".slot"},        32'(slot),        32'(eslot));
        chk({tag, ".locked"},      32'(locked),      32'(elk));
        chk({tag, ".sync_err"},    32'(sync_err),    32'(eerr));
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_buf.delete();
        m_y   = '0;
        m_fv  = 1'b0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input bit v, input bit s, input logic [W-1:0] dd);
        m_fv  = 1'b0;
        m_err = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (s) begin
                    m_locked = 1'b1;
                    m_buf = {dd};
                end
            end else if (s) begin
                m_err = (m_buf.size() != 0);
                m_buf = {dd};
            end else if (m_buf.size() == 0) begin
                m_err    = 1'b1;
                m_locked = 1'b0;
            end else begin
                m_buf.push_back(dd);
                if (m_buf.size() == 4) begin
                    m_y  = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                    m_fv = 1'b1;
                    m_buf.delete();
                end
            end
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cycle(input bit v, input bit s, input logic [W-1:0] dd);
        @(negedge clk);
        valid_in = v;
        sync     = s;
        d        = dd;
        @(posedge clk);
        #1;
        model_step(v, s, dd);
    endtask

    initial begin
        // Pre-sync junk, basic frame, back-to-back frame, sync with valid_in=0.
        tbl[0]  = '{1'b1, 1'b0, 4'hF, 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 4'h1, 16'h0000, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 4'h2, 16'h0000, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 4'h4, 16'h0000, 1'b0, 2'd3, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 4'h8, 16'h8421, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 4'hA, 16'h8421, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 4'hB, 16'h8421, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 4'hC, 16'h8421, 1'b0, 2'd3, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 4'hD, 16'hDCBA, 1'b1, 2'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 4'h3, 16'hDCBA, 1'b0, 2'd0, 1'b1, 1'b0};
        // Early sync at slot 2.
        tbl[10] = '{1'b1, 1'b1, 4'h1, 16'hDCBA, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 4'h2, 16'hDCBA, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 4'h5, 16'hDCBA, 1'b0, 2'd1, 1'b1, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 4'h6, 16'hDCBA, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 4'h7, 16'hDCBA, 1'b0, 2'd3, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 4'h9, 16'h9765, 1'b1, 2'd0, 1'b1, 1'b0};
        // Missing sync, ignored sample, realignment.
        tbl[16] = '{1'b1, 1'b0, 4'h3, 16'h9765, 1'b0, 2'd0, 1'b0, 1'b1};
        tbl[17] = '{1'b1, 1'b0, 4'h4, 16'h9765, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 4'hE, 16'h9765, 1'b0, 2'd1, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 4'h1, 16'h9765, 1'b0, 2'd2, 1'b1, 1'b0};
        tbl[20] = '{1'b1, 1'b0, 4'h2, 16'h9765, 1'b0, 2'd3, 1'b1, 1'b0};
        tbl[21] = '{1'b1, 1'b0, 4'h3, 16'h321E, 1'b1, 2'd0, 1'b1, 1'b0};

        reset    = 1'b1;
        valid_in = 1'b0;
        sync     = 1'b0;
        d        = '0;
        model_reset();
        #2;
        chk_all("reset", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].v, tbl[i].s, tbl[i].d);
            chk_all($sformatf("vec%0d", i), tbl[i].ey, tbl[i].efv, tbl[i].eslot, tbl[i].elk, tbl[i].eerr);
        end

        // Stall between lanes 1 and 2: y and slot must hold.
        cycle(1'b1, 1'b1, 4'h1);
        cycle(1'b1, 1'b0, 4'h0);
        chk_all("stall_pre", 16'h321E, 1'b0, 2'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 4'hF);
            chk_all($sformatf("stall%0d", i), 16'h321E, 1'b0, 2'd2, 1'b1, 1'b0);
        end
        cycle(1'b1, 1'b0, 4'h0);
        chk_all("stall_l2", 16'h321E, 1'b0, 2'd3, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 4'h0);
        chk_all("stall_done", 16'h0001, 1'b1, 2'd0, 1'b1, 1'b0);

        // Reset raised between edges, right after a frame completed.
        cycle(1'b1, 1'b1, 4'h7);
        cycle(1'b1, 1'b0, 4'h7);
        cycle(1'b1, 1'b0, 4'h7);
        cycle(1'b1, 1'b0, 4'h7);
        chk_all("pre_arst", 16'h7777, 1'b1, 2'd0, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("arst", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 1'b0, 4'h5);
        chk_all("post_arst_hunt", 16'h0000, 1'b0, 2'd0, 1'b0, 1'b0);

        // Random traffic, mostly well-framed with occasional misplaced syncs and stalls.
        for (int i = 0; i < 400; i++) begin
            bit v;
            bit s;
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 9) == 0) ^ (m_locked ? (m_buf.size() == 0) : ($urandom_range(0, 2) == 0));
            cycle(v, s, W'($urandom));
            chk_all("rand", m_y, m_fv, 2'(m_buf.size()), m_locked, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tdm_demultiplexer_1_4.md
# tdm_demultiplexer_1_4

Registered 1:4 time-division demultiplexer. It receives a sample stream produced by a 4:1 multiplexer driven by a rotating 2-bit select, and de-interleaves it back into a 4-lane parallel word. Frame alignment comes from a slot-0 sync marker. It sits on the receive side of the lane-serialising path and feeds the parallel consumer one assembled frame at a time.

## Interface
- WIDTH, 1, bit width of one lane sample
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- valid_in  in  1  d/sync carry a sample this cycle
- sync  in  1  sample on d belongs to slot 0 (frame start); qualified by valid_in
- d  in  WIDTH  lane sample
- y  out  4*WIDTH  last complete frame; lane i at y[i*WIDTH +: WIDTH]
- frame_valid  out  1  one-cycle pulse: y was just updated with a new frame
- slot  out  2  slot index expected for the next valid sample
- locked  out  1  frame alignment established
- sync_err  out  1  one-cycle pulse: sync marker out of place, frame dropped

## Operation
- Reset (async, immediate, no clock needed) clears: y=0, frame_valid=0, slot=0, locked=0, sync_err=0, internal lane shadows 0, state HUNT.
- Clock-domain events occur only on cycles with valid_in=1. With valid_in=0, all state holds, and frame_valid and sync_err are 0.
- State HUNT (locked=0):
  - valid_in & !sync: sample discarded, no change.
  - valid_in & sync: shadow[0]<=d, slot<=1, go to LOCKED.
- State LOCKED (locked=1), on valid_in:
  - sync & slot==0: shadow[0]<=d, slot<=1 (normal frame start).
  - !sync & slot in {1,2}: shadow[slot]<=d, slot<=slot+1.
  - !sync & slot==3: y<={d, shadow[2], shadow[1], shadow[0]}, frame_valid<=1, slot<=0 (wrap).
  - sync & slot!=0 (early sync): partial frame discarded, sync_err<=1, shadow[0]<=d, slot<=1, stays LOCKED.
  - !sync & slot==0 (missing sync): sync_err<=1, sample discarded, slot<=0, go to HUNT.
- y is never partially updated. It changes only on frame completion and holds between frames.
- Shadows are not cleared on discard. Stale lanes are always overwritten before the next y load.

## Timing
- All outputs are registered. frame_valid, new y and slot=0 are all visible after the clock edge that samples lane 3: latency 1 edge from the final sample.
- Minimum frame period 4 cycles. Back-to-back frames (sync on the cycle after lane 3) are sustained with no bubble, and frame_valid pulses every 4th edge.
- frame_valid and sync_err are mutually exclusive and each lasts exactly 1 cycle.
- sync asserted with valid_in=0 is ignored.
- Reset asserted mid-frame discards the partial frame. After reset deassertion, the block waits in HUNT for the next sync.

## Test plan
- Async reset: drive a frame to completion, then raise reset between clock edges. Required: y=0, locked=0, slot=0, frame_valid=0 immediately, before the next edge.
- Basic frame, WIDTH=4: sync+d=4'h1, then 4'h2, 4'h4, 4'h8 on consecutive cycles. Required: after the 4th edge y=16'h8421, frame_valid=1 for one cycle, slot=0, locked=1. Data sent before the first sync is ignored.
- Stall, WIDTH=1: send the frame 1,0,0,0 (y=4'b0001) with valid_in=0 for 3 cycles between lanes 1 and 2. Required: y is unchanged during the stall, slot holds at 2, and frame_valid pulses only after the 4th valid sample.
- Back-to-back, WIDTH=4: frames 1,2,4,8 and A,B,C,D contiguous. Required: frame_valid on edges 4 and 8; y=16'h8421, then y=16'hDCBA; locked stays 1.
- Early sync: locked; send sync at slot 2 with d=4'h5, then 4'h6, 4'h7, 4'h9. Required: sync_err pulse on that edge, no frame_valid for the broken frame, then y=16'h9765 with frame_valid.
- Missing sync: after a completed frame, send a sample with sync=0 at slot 0. Required: sync_err pulse, locked=0, and samples ignored until the next sync, which restarts alignment.
